// File: rtl/prog_loader.sv
// Boot loader for the risc16f84 core: parses a counted, checksummed byte stream,
// writes 14-bit words into program RAM and releases core reset once the image is verified.
module prog_loader #(
  parameter int unsigned ADDR_W         = 13,
  parameter int unsigned MAX_WORDS      = 1024,
  parameter int unsigned RELEASE_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  input  logic              restart,
  output logic              pram_we,
  output logic [ADDR_W-1:0] pram_addr,
  output logic [13:0]       pram_wdata,
  output logic              core_reset,
  output logic              load_done,
  output logic              load_err
);

  localparam int unsigned RelW = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;

  typedef enum logic [2:0] {
    StCntHi, StCntLo, StDataHi, StDataLo, StChk, StRelease, StRun, StError
  } state_e;

  state_e            state_q, state_d;
  logic [7:0]        sum_q, sum_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [15:0]       idx_q, idx_d;
  logic [5:0]        hi_q, hi_d;
  logic [RelW-1:0]   rel_q, rel_d;
  logic              we_d;
  logic [ADDR_W-1:0] addr_d;
  logic [13:0]       wdata_d;
  logic              rx_ready_d, core_reset_d, load_done_d, load_err_d;
  logic              accept;
  logic [15:0]       n_word;

  assign accept = rx_valid & rx_ready;
  assign n_word = {cnt_q[15:8], rx_data};

  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    hi_d    = hi_q;
    rel_d   = '0;
    we_d    = 1'b0;
    addr_d  = pram_addr;
    wdata_d = pram_wdata;

    if (accept) sum_d = sum_q + rx_data;

    case (state_q)
      StCntHi: begin
        if (accept) begin
          cnt_d[15:8] = rx_data;
          state_d     = StCntLo;
        end
      end
      StCntLo: begin
        if (accept) begin
          cnt_d[7:0] = rx_data;
          if (n_word > 16'(MAX_WORDS)) state_d = StError;
          else if (n_word == 16'd0)    state_d = StChk;
          else                         state_d = StDataHi;
        end
      end
      StDataHi: begin
        if (accept) begin
          if (rx_data[7:6] != 2'b00) begin
            state_d = StError;
          end else begin
            hi_d    = rx_data[5:0];
            state_d = StDataLo;
          end
        end
      end
      StDataLo: begin
        if (accept) begin
          we_d    = 1'b1;
          addr_d  = idx_q[ADDR_W-1:0];
          wdata_d = {hi_q, rx_data};
          idx_d   = idx_q + 16'd1;
          state_d = (idx_q == cnt_q - 16'd1) ? StChk : StDataHi;
        end
      end
      StChk: begin
        if (accept) state_d = (sum_d == 8'd0) ? StRelease : StError;
      end
      StRelease: begin
        // Counter restarts at zero on entry; RUN is entered on the RELEASE_CYCLES-th edge.
        rel_d = rel_q + 1'b1;
        if (rel_q == RelW'(RELEASE_CYCLES - 1)) state_d = StRun;
      end
      StRun, StError: begin
        if (restart) begin
          state_d = StCntHi;
          sum_d   = 8'd0;
          idx_d   = 16'd0;
        end
      end
      default: state_d = StError;
    endcase

    rx_ready_d   = (state_d == StCntHi) || (state_d == StCntLo) || (state_d == StDataHi) ||
                   (state_d == StDataLo) || (state_d == StChk);
    core_reset_d = (state_d != StRun);
    load_done_d  = (state_d == StRun);
    load_err_d   = (state_d == StError);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StCntHi;
      sum_q      <= 8'd0;
      cnt_q      <= 16'd0;
      idx_q      <= 16'd0;
      hi_q       <= 6'd0;
      rel_q      <= '0;
      rx_ready   <= 1'b0;
      pram_we    <= 1'b0;
      pram_addr  <= '0;
      pram_wdata <= 14'd0;
      core_reset <= 1'b1;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      state_q    <= state_d;
      sum_q      <= sum_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      hi_q       <= hi_d;
      rel_q      <= rel_d;
      rx_ready   <= rx_ready_d;
      pram_we    <= we_d;
      pram_addr  <= addr_d;
      pram_wdata <= wdata_d;
      core_reset <= core_reset_d;
      load_done  <= load_done_d;
      load_err   <= load_err_d;
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed/randomized bench for prog_loader: builds byte streams from word lists and
// predicts RAM writes, final status and release timing from the stream format rules.
module tb_prog_loader;
  localparam int MAX_WORDS = 1024;
  localparam int REL       = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        restart = 1'b0;
  logic        rx_ready, pram_we, core_reset, load_done, load_err;
  logic [12:0] pram_addr;
  logic [13:0] pram_wdata;

  prog_loader #(.ADDR_W(13), .MAX_WORDS(MAX_WORDS), .RELEASE_CYCLES(REL)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .restart   (restart),
    .pram_we   (pram_we),
    .pram_addr (pram_addr),
    .pram_wdata(pram_wdata),
    .core_reset(core_reset),
    .load_done (load_done),
    .load_err  (load_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];
  logic        prev_cr = 1'b1;
  int          fall_cyc = -1;
  int          chk_cyc = 0;
  int          last_acc = 0;
  bit          gaps = 1'b0;
  logic [13:0] wlist[0:1099];

  // Observe RAM writes and the core_reset falling edge away from the active edge.
  always @(negedge clk) begin
    if (pram_we) got_q.push_back({3'b0, pram_addr, 2'b0, pram_wdata});
    if (prev_cr && !core_reset) fall_cyc = cyc;
    prev_cr = core_reset;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic send(input logic [7:0] b);
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        @(negedge clk);
      end
    end
    rx_valid = 1'b1;
    rx_data  = b;
    for (int t = 0; t < 50 && !rx_ready; t++) @(negedge clk);
    check("rx_ready_wait", rx_ready, 1);
    last_acc = cyc + 1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic rand_words(input int n);
    for (int i = 0; i < n; i++) wlist[i] = 14'($urandom);
  endtask

  // bad_at >= 0 replaces that word's HI byte with 0x40; adj is added to the correct checksum.
  task automatic load(input int n, input int adj, input int bad_at);
    logic [7:0]  sum;
    logic [7:0]  hi;
    logic [7:0]  lo;
    logic [7:0]  chk;
    logic [12:0] a;
    logic [15:0] nn;
    bit          exp_err;
    int          m;
    sum      = 8'd0;
    exp_err  = 1'b0;
    fall_cyc = -1;
    exp_q.delete();
    got_q.delete();
    nn = 16'(n);
    send(nn[15:8]);
    send(nn[7:0]);
    sum = nn[15:8] + nn[7:0];
    if (n > MAX_WORDS) begin
      exp_err = 1'b1;
    end else begin
      for (int i = 0; i < n; i++) begin
        hi = (i == bad_at) ? 8'h40 : {2'b00, wlist[i][13:8]};
        send(hi);
        sum = sum + hi;
        if (i == bad_at) begin
          exp_err = 1'b1;
          break;
        end
        lo = wlist[i][7:0];
        send(lo);
        sum = sum + lo;
        a = 13'(i);
        exp_q.push_back({3'b0, a, 2'b0, wlist[i]});
      end
      if (!exp_err) begin
        chk = 8'(-sum) + 8'(adj);
        send(chk);
        chk_cyc = last_acc;
        exp_err = (8'(adj) != 8'd0);
      end
    end
    for (int t = 0; t < 100 && !(load_done || load_err); t++) @(negedge clk);
    repeat (2) @(negedge clk);
    check("load_err", load_err, 32'(exp_err));
    check("load_done", load_done, 32'(!exp_err));
    check("core_reset", core_reset, 32'(exp_err));
    check("rx_ready_idle", rx_ready, 0);
    check("write_count", got_q.size(), exp_q.size());
    m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < m; i++) check("write_addr_data", got_q[i], exp_q[i]);
    if (!exp_err) check("release_delay", 32'(fall_cyc - chk_cyc), REL);
  endtask

  task automatic do_restart();
    @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    check("rst_err", load_err, 0);
    check("rst_done", load_done, 0);
    check("rst_core_reset", core_reset, 1);
    check("rst_rx_ready", rx_ready, 1);
  endtask

  task automatic check_reset_vals();
    check("r_core_reset", core_reset, 1);
    check("r_rx_ready", rx_ready, 0);
    check("r_we", pram_we, 0);
    check("r_addr", pram_addr, 0);
    check("r_wdata", pram_wdata, 0);
    check("r_done", load_done, 0);
    check("r_err", load_err, 0);
  endtask

  initial begin
    #1 reset = 1'b0;
    #11;
    check_reset_vals();
    reset = 1'b1;
    #1 check("rx_ready_pre_edge", rx_ready, 0);
    @(negedge clk);
    check("rx_ready_post_edge", rx_ready, 1);

    // 1: fixed three-word image
    wlist[0] = 14'h2805;
    wlist[1] = 14'h3FFF;
    wlist[2] = 14'h0000;
    load(3, 0, -1);
    do_restart();
    // 2: bad checksum
    load(3, 1, -1);
    check("err_not_run", load_done, 0);
    do_restart();
    // 3: empty image
    load(0, 0, -1);
    do_restart();
    // 4: oversize count, then a valid image with random gaps
    load(MAX_WORDS + 1, 0, -1);
    do_restart();
    gaps = 1'b1;
    rand_words(5);
    load(5, 0, -1);
    do_restart();
    // 5: bad HI byte in word 1
    rand_words(4);
    load(4, 0, 1);
    do_restart();
    // largest legal image
    gaps = 1'b0;
    rand_words(MAX_WORDS);
    load(MAX_WORDS, 0, -1);
    do_restart();
    // 6: async reset in the middle of word 2
    gaps = 1'b1;
    rand_words(5);
    send(8'h00);
    send(8'h05);
    for (int i = 0; i < 2; i++) begin
      send({2'b00, wlist[i][13:8]});
      send(wlist[i][7:0]);
    end
    send({2'b00, wlist[2][13:8]});
    #2 reset = 1'b0;
    #1 check_reset_vals();
    @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    check("post_reset_rx_ready", rx_ready, 1);
    rand_words(5);
    load(5, 0, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
